counter_run_ctrl: RTL and testbench

- Sequencer for the demo's 8-bit enable-gated up-counter datapath.
- Drives the counter's enable and clear so it runs in programmed bursts: clear, count for RUN_LEN cycles, optional idle gap, optional automatic re-arm.
- Replaces the manual enable toggling on ui_in[0] with start/stop/hold controls.
- Sits between the top-level ui_in decode and the counter instance.

---
 rtl/counter_ctrl_pkg.sv | 11 +
 rtl/len_down_counter.sv | 36 +++
 rtl/counter_run_ctrl.sv | 159 +++++++++++++++
 tb/tb_counter_run_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the burst sequencer: state encoding and default datapath width.
package counter_ctrl_pkg;

    localparam int unsigned CtrWidth = 8;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StClear = 2'd1;
    localparam logic [1:0] StRun   = 2'd2;
    localparam logic [1:0] StGap   = 2'd3;

endpackage

// File: rtl/len_down_counter.sv
// Loadable down-counter used as the RUN and GAP timers; saturates at zero.
module len_down_counter #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic [Width-1:0] count_o,
    output logic             zero_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/counter_run_ctrl.sv
// Burst sequencer for the enable-gated up-counter: clear, run for a programmed length,
// optional gap and automatic re-arm. All control outputs come straight from flops.
module counter_run_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = CtrWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             auto_rearm,
    input  logic [WIDTH-1:0] run_len,
    input  logic [WIDTH-1:0] gap_len,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remaining,
    output logic [1:0]       state
);

    localparam logic [WIDTH:0] CountOne  = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] CountFull = {1'b1, {WIDTH{1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] run_len_q, run_len_d;
    logic [WIDTH-1:0] gap_len_q, gap_len_d;
    logic             cnt_en_q, cnt_en_d;
    logic             cnt_clr_q, cnt_clr_d;
    logic             done_q, done_d;
    logic             relatch;

    logic             run_load, run_dec, run_zero;
    logic [WIDTH:0]   run_load_val, run_cnt;
    logic             gap_load, gap_dec, gap_zero;
    logic [WIDTH:0]   gap_load_val, gap_cnt;

    len_down_counter #(
        .Width (WIDTH + 1)
    ) u_run_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (run_load),
        .load_val_i (run_load_val),
        .dec_i      (run_dec),
        .count_o    (run_cnt),
        .zero_o     (run_zero)
    );

    len_down_counter #(
        .Width (WIDTH + 1)
    ) u_gap_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (gap_load),
        .load_val_i (gap_load_val),
        .dec_i      (gap_dec),
        .count_o    (gap_cnt),
        .zero_o     (gap_zero)
    );

    always_comb begin
        state_d      = state_q;
        run_len_d    = run_len_q;
        gap_len_d    = gap_len_q;
        done_d       = 1'b0;
        relatch      = 1'b0;
        run_load     = 1'b0;
        run_load_val = '0;
        run_dec      = 1'b0;
        gap_load     = 1'b0;
        gap_load_val = '0;
        gap_dec      = 1'b0;

        if (stop) begin
            // Abort: timers are zeroed so remaining reads 0 in IDLE.
            state_d  = StIdle;
            run_load = 1'b1;
            gap_load = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_d = StClear;
                        relatch = 1'b1;
                    end
                end
                StClear: begin
                    state_d      = StRun;
                    run_load     = 1'b1;
                    run_load_val = (run_len_q == '0) ? CountFull : {1'b0, run_len_q};
                end
                StRun: begin
                    // Only an increment actually issued this cycle consumes the budget.
                    if (cnt_en_q) begin
                        run_dec = 1'b1;
                        if ((run_cnt == CountOne) || run_zero) begin
                            done_d = 1'b1;
                            if (!auto_rearm) begin
                                state_d = StIdle;
                            end else if (gap_len_q != '0) begin
                                state_d      = StGap;
                                gap_load     = 1'b1;
                                gap_load_val = {1'b0, gap_len_q};
                            end else begin
                                state_d = StClear;
                                relatch = 1'b1;
                            end
                        end
                    end
                end
                StGap: begin
                    gap_dec = 1'b1;
                    if ((gap_cnt == CountOne) || gap_zero) begin
                        state_d = StClear;
                        relatch = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (relatch) begin
            run_len_d = run_len;
            gap_len_d = gap_len;
        end

        cnt_en_d  = (state_d == StRun) && !hold;
        cnt_clr_d = (state_d == StClear);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            run_len_q <= '0;
            gap_len_q <= '0;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_len_q <= run_len_d;
            gap_len_q <= gap_len_d;
            cnt_en_q  <= cnt_en_d;
            cnt_clr_q <= cnt_clr_d;
            done_q    <= done_d;
        end
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_clr   = cnt_clr_q;
    assign done      = done_q;
    assign busy      = (state_q != StIdle);
    assign state     = state_q;
    assign remaining = run_cnt[WIDTH-1:0];

endmodule

// File: tb/tb_counter_run_ctrl.sv
// Directed bench for counter_run_ctrl with an attached 8-bit up-counter.
module tb_counter_run_ctrl;
    import counter_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, stop = 1'b0, hold = 1'b0, auto_rearm = 1'b0;
    logic [7:0] run_len = 8'd0, gap_len = 8'd0;
    logic       cnt_en, cnt_clr, busy, done;
    logic [7:0] remaining;
    logic [1:0] state;
    logic [7:0] ctr = 8'd0;

    int checks = 0;
    int errors = 0;

    counter_run_ctrl #(
        .WIDTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .auto_rearm (auto_rearm),
        .run_len    (run_len),
        .gap_len    (gap_len),
        .cnt_en     (cnt_en),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .done       (done),
        .remaining  (remaining),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Counter datapath driven by the sequencer; not touched by rst.
    always @(posedge clk) begin
        if (cnt_clr) ctr <= 8'd0;
        else if (cnt_en) ctr <= ctr + 8'd1;
    end

    typedef struct packed {
        logic       st, sp, hd, ar;
        logic [7:0] rl, gl;
        logic [1:0] e_state;
        logic       e_en, e_clr, e_busy, e_done;
        logic [7:0] e_rem;
    } vec_t;

    vec_t vecs [23];

    function automatic vec_t mk(input int st, sp, hd, ar, rl, gl, s, en, clr, bz, dn, rem);
        vec_t v;
        v.st = st[0]; v.sp = sp[0]; v.hd = hd[0]; v.ar = ar[0];
        v.rl = rl[7:0]; v.gl = gl[7:0];
        v.e_state = s[1:0]; v.e_en = en[0]; v.e_clr = clr[0];
        v.e_busy = bz[0]; v.e_done = dn[0]; v.e_rem = rem[7:0];
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int max_n, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!done && n < max_n);
        check("wait_done", int'(done), 1);
    endtask

    // One non-rearming burst; hold is raised while hold_from <= RUN cycles seen < hold_from+hold_n.
    task automatic burst(input logic [7:0] rl, input int hold_from, input int hold_n,
                         output int en_n, output int run_n, output int clr_n,
                         output int steps, output int first_rem, output int max_ctr);
        en_n = 0; run_n = 0; clr_n = 0; steps = 0; first_rem = -1; max_ctr = 0;
        run_len = rl; gap_len = 8'd0; auto_rearm = 1'b0; start = 1'b1;
        do begin
            hold = (run_n >= hold_from) && (run_n < hold_from + hold_n);
            step();
            start = 1'b0;
            steps++;
            if (cnt_en) en_n++;
            if (cnt_clr) clr_n++;
            if (state == StRun) begin
                if (run_n == 0) first_rem = int'(remaining);
                run_n++;
            end
            if (int'(ctr) > max_ctr) max_ctr = int'(ctr);
        end while (!done && steps < 400);
        hold = 1'b0;
        check("burst_done", int'(done), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en_n, run_n, clr_n, steps, first_rem, max_ctr, n, snap;

        vecs[0]  = mk(1, 1, 0, 0, 3, 0,  0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 3, 0,  1, 0, 1, 1, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 3, 0,  2, 1, 0, 1, 0, 3);
        vecs[3]  = mk(1, 0, 0, 0, 7, 0,  2, 1, 0, 1, 0, 2);
        vecs[4]  = mk(0, 0, 1, 0, 7, 0,  2, 0, 0, 1, 0, 1);
        vecs[5]  = mk(0, 0, 1, 0, 7, 0,  2, 0, 0, 1, 0, 1);
        vecs[6]  = mk(0, 0, 0, 0, 7, 0,  2, 1, 0, 1, 0, 1);
        vecs[7]  = mk(0, 0, 0, 0, 7, 0,  0, 0, 0, 0, 1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 7, 0,  0, 0, 0, 0, 0, 0);
        vecs[9]  = mk(1, 0, 0, 1, 2, 2,  1, 0, 1, 1, 0, 0);
        vecs[10] = mk(0, 0, 0, 1, 2, 2,  2, 1, 0, 1, 0, 2);
        vecs[11] = mk(0, 0, 0, 1, 2, 2,  2, 1, 0, 1, 0, 1);
        vecs[12] = mk(0, 0, 0, 1, 2, 2,  3, 0, 0, 1, 1, 0);
        vecs[13] = mk(0, 0, 0, 1, 2, 2,  3, 0, 0, 1, 0, 0);
        vecs[14] = mk(0, 0, 0, 1, 1, 2,  1, 0, 1, 1, 0, 0);
        vecs[15] = mk(0, 0, 0, 1, 1, 2,  2, 1, 0, 1, 0, 1);
        vecs[16] = mk(0, 0, 0, 1, 1, 2,  3, 0, 0, 1, 1, 0);
        vecs[17] = mk(0, 1, 0, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        vecs[18] = mk(0, 0, 0, 1, 1, 2,  0, 0, 0, 0, 0, 0);
        vecs[19] = mk(1, 0, 0, 0, 5, 0,  1, 0, 1, 1, 0, 0);
        vecs[20] = mk(0, 0, 0, 0, 5, 0,  2, 1, 0, 1, 0, 5);
        vecs[21] = mk(0, 0, 0, 0, 5, 0,  2, 1, 0, 1, 0, 4);
        vecs[22] = mk(0, 1, 0, 0, 5, 0,  0, 0, 0, 0, 0, 0);

        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_state", int'(state), int'(StIdle));
        check("rst_en", int'(cnt_en), 0);
        check("rst_clr", int'(cnt_clr), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rem", int'(remaining), 0);

        // Table-driven vectors
        for (int i = 0; i < 23; i++) begin
            start = vecs[i].st; stop = vecs[i].sp; hold = vecs[i].hd;
            auto_rearm = vecs[i].ar; run_len = vecs[i].rl; gap_len = vecs[i].gl;
            step();
            check($sformatf("v%0d_state", i), int'(state), int'(vecs[i].e_state));
            check($sformatf("v%0d_en", i), int'(cnt_en), int'(vecs[i].e_en));
            check($sformatf("v%0d_clr", i), int'(cnt_clr), int'(vecs[i].e_clr));
            check($sformatf("v%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("v%0d_done", i), int'(done), int'(vecs[i].e_done));
            check($sformatf("v%0d_rem", i), int'(remaining), int'(vecs[i].e_rem));
        end
        start = 1'b0; stop = 1'b0; hold = 1'b0; auto_rearm = 1'b0;
        check("stop_run_ctr_kept", int'(ctr), 2);
        step();

        // Plain burst of 10
        burst(8'd10, 1000, 0, en_n, run_n, clr_n, steps, first_rem, max_ctr);
        check("b10_en_cycles", en_n, 10);
        check("b10_run_cycles", run_n, 10);
        check("b10_clr_cycles", clr_n, 1);
        check("b10_latency", steps, 12);
        check("b10_first_rem", first_rem, 10);
        check("b10_ctr", int'(ctr), 10);
        step();
        check("b10_idle", int'(state), int'(StIdle));
        check("b10_done_pulse", int'(done), 0);

        // Burst of 6 with 3 held cycles
        burst(8'd6, 2, 3, en_n, run_n, clr_n, steps, first_rem, max_ctr);
        check("b6h_en_cycles", en_n, 6);
        check("b6h_run_cycles", run_n, 9);
        check("b6h_latency", steps, 11);
        check("b6h_ctr", int'(ctr), 6);
        step();

        // run_len 0 means a full 256-increment burst
        burst(8'd0, 1000, 0, en_n, run_n, clr_n, steps, first_rem, max_ctr);
        check("b256_en_cycles", en_n, 256);
        check("b256_latency", steps, 258);
        check("b256_first_rem", first_rem, 0);
        check("b256_max_ctr", max_ctr, 255);
        check("b256_ctr_wrap", int'(ctr), 0);
        n = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done) n++;
        end
        check("b256_single_done", n, 0);

        // Auto re-arm with gap 3: period 8
        auto_rearm = 1'b1; run_len = 8'd4; gap_len = 8'd3; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(50, n);
        check("ar_first", n, 5);
        check("ar_gap_state", int'(state), int'(StGap));
        wait_done(50, n);
        check("ar_period1", n, 8);
        wait_done(50, n);
        check("ar_period2", n, 8);
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("ar_stop_gap", int'(state), int'(StIdle));
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (cnt_clr || busy) n++;
        end
        check("ar_no_clear_after_stop", n, 0);

        // Auto re-arm without gap: period 5
        gap_len = 8'd0; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(50, n);
        check("ar0_first", n, 5);
        check("ar0_clear_state", int'(state), int'(StClear));
        wait_done(50, n);
        check("ar0_period1", n, 5);
        wait_done(50, n);
        check("ar0_period2", n, 5);
        stop = 1'b1; auto_rearm = 1'b0;
        step();
        stop = 1'b0;
        step();

        // Reset mid-RUN at remaining 5
        run_len = 8'd10; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!(state == StRun && remaining == 8'd5) && n < 30) begin
            step();
            n++;
        end
        check("mid_rem5_reached", int'(remaining), 5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_state", int'(state), int'(StIdle));
        check("mid_rst_en", int'(cnt_en), 0);
        check("mid_rst_rem", int'(remaining), 0);
        check("mid_rst_done", int'(done), 0);
        snap = int'(ctr);
        check("mid_rst_ctr_nonzero", int'(ctr != 8'd0), 1);
        step();
        step();
        step();
        check("mid_rst_ctr_kept", int'(ctr), snap);
        check("mid_rst_idle", int'(state), int'(StIdle));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
